mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and Hi/Lo width; legal values are even numbers from 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request to begin an operation.
REQ-005 The block SHALL have port op, input, 2 bits: bit0 selects 0 = multiply, 1 = divide; bit1 selects 1 = unsigned (used only when MULTDIV_UNSIGNED_EN is defined).
REQ-006 The block SHALL have ports a and b, input, WIDTH bits: multiplicand/multiplier, or dividend/divisor.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is iterating.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-009 The block SHALL have port div_zero, output, 1 bit: divide-by-zero flag, pulsed together with done.
REQ-010 The block SHALL have ports hi and lo, output, WIDTH bits: the result registers.

Function
REQ-011 The FSM SHALL have the states IDLE, MULT, DIV and FIN; FIN always moves to IDLE on the next edge.
REQ-012 In IDLE, start SHALL latch a, b and op; the next state is MULT for op[0]=0, DIV for op[0]=1 with b!=0, and FIN for op[0]=1 with b==0.
REQ-013 start SHALL be ignored in MULT, DIV and FIN, with no queuing.
REQ-014 Multiply SHALL use radix-2 Booth with an internal iteration counter, taking exactly WIDTH cycles in MULT; the 2*WIDTH-bit signed product goes to {hi,lo}.
REQ-015 Divide SHALL use restoring division on operand magnitudes over exactly WIDTH cycles in DIV, with lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-016 The signed case most-negative / -1 SHALL produce lo = most-negative and hi = 0, with no flag.
REQ-017 hi and lo SHALL update only on the edge entering FIN, and SHALL hold their values at all other times.
REQ-018 busy SHALL equal (state is MULT or DIV); done SHALL equal (state is FIN); both are registered-state decodes.
REQ-019 Latency from the start edge to the done cycle SHALL be WIDTH+1 cycles for a normal operation, and 1 cycle for divide-by-zero.
REQ-020 On divide-by-zero, div_zero SHALL be 1 during FIN and hi and lo SHALL keep their previous values.

Reset
REQ-021 While rst is high, state SHALL be IDLE and hi, lo, busy, done, div_zero and all internal registers SHALL be 0, independent of clk.
REQ-022 An rst assertion in the middle of an operation SHALL abort it, with no done pulse afterwards; the first start after rst deasserts is accepted normally.

Configuration
REQ-023 With MULTDIV_UNSIGNED_EN defined, op[1]=1 SHALL select unsigned multiply (multu) and unsigned divide (divu): operands are zero-extended and no sign correction is applied.
REQ-024 Without MULTDIV_UNSIGNED_EN, op[1] SHALL be ignored and all operations SHALL be signed; the unsigned logic is not synthesised.
REQ-025 Latency and the handshake SHALL be identical with and without MULTDIV_UNSIGNED_EN.

Structure
REQ-026 The shared package mult_div_pkg SHALL hold the FSM state encoding, the op code constants, and the default WIDTH.
REQ-027 One combinational sub-module, div_restore_step, SHALL perform a single shift-subtract-restore iteration; Booth stays inline.

Verification
REQ-028 With WIDTH=32, mult a=7, b=-3 SHALL give busy high for 32 cycles, done at cycle 33, hi=0xFFFFFFFF and lo=0xFFFFFFEB.
REQ-029 With WIDTH=32, div a=-7, b=2 SHALL give lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0, and done at cycle 33.
REQ-030 Div a=5, b=0, with hi/lo preloaded from a prior mult, SHALL give done and div_zero at cycle 1, busy never high, and hi/lo unchanged.
REQ-031 A second start pulsed at cycle 5 of a running mult SHALL be ignored, giving exactly one done pulse and the first operation's result.
REQ-032 rst asserted at cycle 10 of a div SHALL immediately clear hi, lo and busy, and no done SHALL follow.
REQ-033 With MULTDIV_UNSIGNED_EN, multu 0xFFFFFFFF * 2 SHALL give hi=1 and lo=0xFFFFFFFE; without the macro, the same stimulus SHALL give hi=0xFFFFFFFF and lo=0xFFFFFFFE.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared encodings for mult_div_unit: FSM states, op codes and the default operand width.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int OP_DIV_BIT = 0;
  localparam int OP_UNS_BIT = 1;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MULU = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

endpackage

// File: rtl/mult_div_unit_div_restore_step.sv
// One shift-subtract-restore iteration of unsigned restoring division (combinational).
// The next dividend bit comes from the top of quoIn; the new quotient bit enters at its bottom.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {remIn, quoIn[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  // Bit WIDTH of diff is the borrow: set means the trial subtract went negative, so restore.
  assign remOut = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quoOut = {quoIn[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative Booth multiplier / restoring divider; WIDTH+1 cycles per op (1 for divide-by-zero).
// start is honoured only in IDLE and dropped otherwise; MULTDIV_UNSIGNED_EN adds op[1] unsigned ops.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t         state, nextState;
  logic [CW-1:0]  iterCnt;
  logic [WIDTH:0] acc;       // Booth accumulator; low bits double as the partial remainder
  logic [WIDTH-1:0] qReg;    // multiplier being consumed, or dividend turning into quotient
  logic           qm1;
  logic [WIDTH:0] operandM;  // extended multiplicand, or divisor magnitude
  logic           hiCorr;
  logic           negQuo;
  logic           negRem;
  logic           dzFlag;

  logic opUns;
`ifdef MULTDIV_UNSIGNED_EN
  assign opUns = op[OP_UNS_BIT];
`else
  logic unusedOpBit;
  assign opUns       = 1'b0;
  assign unusedOpBit = op[OP_UNS_BIT];
`endif

  logic isDiv, bZero, lastIter, aNeg, bNeg;
  logic [WIDTH-1:0] magA, magB;

  assign isDiv    = op[OP_DIV_BIT];
  assign bZero    = (b == '0);
  assign lastIter = (iterCnt == CW'(WIDTH - 1));
  assign aNeg     = !opUns && a[WIDTH-1];
  assign bNeg     = !opUns && b[WIDTH-1];
  assign magA     = aNeg ? -a : a;
  assign magB     = bNeg ? -b : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!isDiv)     nextState = MULT;
          else if (bZero) nextState = FIN;
          else            nextState = DIV;
        end
      end
      MULT, DIV: if (lastIter) nextState = FIN;
      FIN:       nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  logic [WIDTH:0]   boothSum, boothAcc;
  logic [WIDTH-1:0] boothQ;

  always_comb begin
    boothSum = acc;
    case ({qReg[0], qm1})
      2'b01:   boothSum = acc + operandM;
      2'b10:   boothSum = acc - operandM;
      default: boothSum = acc;
    endcase
    boothAcc = {boothSum[WIDTH], boothSum[WIDTH:1]};
    boothQ   = {boothSum[0], qReg[WIDTH-1:1]};
  end

  logic [WIDTH-1:0] stepRem, stepQuo;

  div_restore_step #(.WIDTH(WIDTH)) uStep (
    .remIn  (acc[WIDTH-1:0]),
    .quoIn  (qReg),
    .divisor(operandM[WIDTH-1:0]),
    .remOut (stepRem),
    .quoOut (stepQuo)
  );

  // Booth treats the multiplier as signed; an unsigned multiplier with its top bit set
  // is short by multiplicand * 2^WIDTH, restored here on the high half.
  logic [WIDTH-1:0] mulHi, divHi, divLo;
  assign mulHi = boothAcc[WIDTH-1:0] + (hiCorr ? operandM[WIDTH-1:0] : '0);
  assign divLo = negQuo ? -stepQuo : stepQuo;
  assign divHi = negRem ? -stepRem : stepRem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iterCnt  <= '0;
      acc      <= '0;
      qReg     <= '0;
      qm1      <= 1'b0;
      operandM <= '0;
      hiCorr   <= 1'b0;
      negQuo   <= 1'b0;
      negRem   <= 1'b0;
      dzFlag   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            iterCnt <= '0;
            acc     <= '0;
            qm1     <= 1'b0;
            dzFlag  <= isDiv && bZero;
            if (!isDiv) begin
              operandM <= opUns ? {1'b0, a} : {a[WIDTH-1], a};
              qReg     <= b;
              hiCorr   <= opUns && b[WIDTH-1];
              negQuo   <= 1'b0;
              negRem   <= 1'b0;
            end else begin
              operandM <= {1'b0, magB};
              qReg     <= magA;
              hiCorr   <= 1'b0;
              negQuo   <= aNeg ^ bNeg;
              negRem   <= aNeg;
            end
          end
        end
        MULT: begin
          acc     <= boothAcc;
          qReg    <= boothQ;
          qm1     <= qReg[0];
          iterCnt <= iterCnt + CW'(1);
          if (lastIter) begin
            hi <= mulHi;
            lo <= boothQ;
          end
        end
        DIV: begin
          acc     <= {1'b0, stepRem};
          qReg    <= stepQuo;
          iterCnt <= iterCnt + CW'(1);
          if (lastIter) begin
            hi <= divHi;
            lo <= divLo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == MULT) || (state == DIV);
  assign done     = (state == FIN);
  assign div_zero = (state == FIN) && dzFlag;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, multi-cycle corner sequences, random ops vs model.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int W = 32;
  localparam int NORMAL_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int applied = 0;
  int miscompares = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input string n, input logic [1:0] o, input logic [W-1:0] x, y, hh, ll);
    vec_t v;
    v.name = n; v.op = o; v.a = x; v.b = y; v.expHi = hh; v.expLo = ll;
    vecs.push_back(v);
  endtask

  // Returns at the falling edge of cycle 1 (the first cycle after the start edge).
  task automatic startOp(input logic [1:0] o, input logic [W-1:0] x, y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic waitDone(output int lat, output int busyCyc);
    lat = 1;
    busyCyc = 0;
    while (!done && lat < 200) begin
      if (busy) busyCyc++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", 64'(done), 64'(1));
  endtask

  task automatic runOp(input logic [1:0] o, input logic [W-1:0] x, y,
                       output int lat, output int busyCyc,
                       output logic [W-1:0] rh, output logic [W-1:0] rl, output logic dz);
    startOp(o, x, y);
    waitDone(lat, busyCyc);
    rh = hi;
    rl = lo;
    dz = div_zero;
  endtask

  // Arithmetic reference: full-width products and truncating division on 64-bit integers.
  task automatic refModel(input logic [1:0] o, input logic [W-1:0] x, y,
                          inout logic [W-1:0] mh, inout logic [W-1:0] ml,
                          output logic dz, output int lat);
    bit          uns;
    longint      sx, sy, q, r;
    logic [63:0] p;
`ifdef MULTDIV_UNSIGNED_EN
    uns = o[1];
`else
    uns = o[1] & 1'b0;
`endif
    dz  = 1'b0;
    lat = NORMAL_LAT;
    if (uns) begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end
    if (!o[0]) begin
      p = 64'(sx * sy);
      mh = p[63:32];
      ml = p[31:0];
    end else if (y == '0) begin
      dz  = 1'b1;
      lat = 1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      ml = 32'(q);
      mh = 32'(r);
    end
  endtask

  function automatic logic [W-1:0] pickOperand();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: begin
        case ($urandom_range(0, 4))
          0:       v = 32'h0000_0000;
          1:       v = 32'h0000_0001;
          2:       v = 32'hFFFF_FFFF;
          3:       v = 32'h8000_0000;
          default: v = 32'h7FFF_FFFF;
        endcase
      end
      1:       v = 32'($urandom_range(0, 40)) - 32'd20;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, busyCyc, doneCnt, firstDone;
    logic [W-1:0] rh, rl, mh, ml, capHi, capLo;
    logic         dz, edz;
    int           elat;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_dz", 64'(div_zero), 64'(0));
    rst = 1'b0;

    // Directed table
    addVec("mul_7_m3",      OP_MUL, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    addVec("div_m7_2",      OP_DIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    addVec("div_minneg_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    addVec("mul_minneg_sq", OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    addVec("div_100_7",     OP_DIV, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
    addVec("div_7_m2",      OP_DIV, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    addVec("mul_max_sq",    OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    addVec("mul_m1_m1",     OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    addVec("div_m8_m3",     OP_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002);
`ifdef MULTDIV_UNSIGNED_EN
    addVec("mulu_ff_2",     OP_MULU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE);
    addVec("mulu_ff_ff",    OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    addVec("divu_ff_2",     OP_DIVU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'h7FFF_FFFF);
`else
    addVec("mulu_ff_2",     OP_MULU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE);
    addVec("mulu_ff_ff",    OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    addVec("divu_ff_2",     OP_DIVU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'h0000_0000);
`endif

    foreach (vecs[i]) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, lat, busyCyc, rh, rl, dz);
      check({vecs[i].name, "_hi"}, 64'(rh), 64'(vecs[i].expHi));
      check({vecs[i].name, "_lo"}, 64'(rl), 64'(vecs[i].expLo));
      check({vecs[i].name, "_dz"}, 64'(dz), 64'(0));
      check({vecs[i].name, "_lat"}, 64'(lat), 64'(NORMAL_LAT));
      check({vecs[i].name, "_busy"}, 64'(busyCyc), 64'(W));
    end

    // Divide by zero keeps the previous multiply result
    runOp(OP_MUL, 32'd7, 32'hFFFF_FFFD, lat, busyCyc, rh, rl, dz);
    runOp(OP_DIV, 32'd5, 32'd0, lat, busyCyc, rh, rl, dz);
    check("dz_lat", 64'(lat), 64'(1));
    check("dz_flag", 64'(dz), 64'(1));
    check("dz_busy", 64'(busy), 64'(0));
    check("dz_hi", 64'(rh), 64'(32'hFFFF_FFFF));
    check("dz_lo", 64'(rl), 64'(32'hFFFF_FFEB));
    @(negedge clk);
    check("dz_done_pulse", 64'(done), 64'(0));
    check("dz_flag_pulse", 64'(div_zero), 64'(0));

    // A start mid-multiply is dropped
    startOp(OP_MUL, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCnt = 0; firstDone = 0; capHi = '0; capLo = '0;
    for (int c = 6; c <= 80; c++) begin
      if (done) begin
        doneCnt++;
        if (firstDone == 0) begin
          firstDone = c;
          capHi = hi;
          capLo = lo;
        end
      end
      @(negedge clk);
    end
    check("ignore_done_count", 64'(doneCnt), 64'(1));
    check("ignore_done_cycle", 64'(firstDone), 64'(NORMAL_LAT));
    check("ignore_hi", 64'(capHi), 64'(0));
    check("ignore_lo", 64'(capLo), 64'(15));

    // Reset in the middle of a divide aborts it
    runOp(OP_MUL, 32'd7, 32'hFFFF_FFFD, lat, busyCyc, rh, rl, dz);
    startOp(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (done) doneCnt++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(doneCnt), 64'(0));
    runOp(OP_MUL, 32'd7, 32'hFFFF_FFFD, lat, busyCyc, rh, rl, dz);
    check("post_abort_lat", 64'(lat), 64'(NORMAL_LAT));
    check("post_abort_lo", 64'(rl), 64'(32'hFFFF_FFEB));

    // Randomized operations against the reference model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mh = '0;
    ml = '0;
    for (int i = 0; i < 250; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = pickOperand();
      y = pickOperand();
      refModel(o, x, y, mh, ml, edz, elat);
      runOp(o, x, y, lat, busyCyc, rh, rl, dz);
      check($sformatf("rnd%0d_op%0d_%h_%h_hi", i, o, x, y), 64'(rh), 64'(mh));
      check($sformatf("rnd%0d_op%0d_%h_%h_lo", i, o, x, y), 64'(rl), 64'(ml));
      check($sformatf("rnd%0d_dz", i), 64'(dz), 64'(edz));
      check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(elat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
